// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle controller:
// FSM states, instruction classes, opcodes and control-strobe encodings.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_EXSTART, S_EXWAIT, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_MOP
   } iclass_t;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JALR   = 2'd2;
   localparam logic [1:0] PC_TRAP   = 2'd3;

   localparam logic [1:0] RES_ALU   = 2'd0;
   localparam logic [1:0] RES_MUL   = 2'd1;
   localparam logic [1:0] RES_MEM   = 2'd2;
   localparam logic [1:0] RES_PC4   = 2'd3;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0] CAUSE_MDIS    = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef struct packed {
      logic    legal;
      iclass_t cls;
   } decode_t;

   function automatic decode_t classify(input logic [6:0] opcode, input logic [1:0] func7b50);
      decode_t d;
      d.legal = 1'b1;
      d.cls   = C_OPIMM;
      case (opcode)
         OP_OP:     d.cls = (func7b50 == 2'b01) ? C_MOP : C_OP;
         OP_IMM:    d.cls = C_OPIMM;
         OP_LOAD:   d.cls = C_LOAD;
         OP_STORE:  d.cls = C_STORE;
         OP_BRANCH: d.cls = C_BRANCH;
         OP_JAL:    d.cls = C_JAL;
         OP_JALR:   d.cls = C_JALR;
         OP_LUI:    d.cls = C_LUI;
         OP_AUIPC:  d.cls = C_AUIPC;
         default:   d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// Combinational ALU-operation decode from the latched instruction class,
// func3 and instr[30] (alt).
module rv_alu_dec
   import rv_ctrl_pkg::*;
(
   input  iclass_t    cls,
   input  logic [2:0] func3,
   input  logic       alt,
   output logic [3:0] aluctl
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      aluctl = ALU_ADD;
      case (cls)
         C_BRANCH: aluctl = ALU_SUB;
         C_LUI:    aluctl = ALU_PASSB;
         C_OP, C_OPIMM: begin
            case (func3)
               3'b000:  aluctl = (cls == C_OP && alt) ? ALU_SUB : ALU_ADD;
               3'b001:  aluctl = ALU_SLL;
               3'b010:  aluctl = ALU_SLT;
               3'b011:  aluctl = ALU_SLTU;
               3'b100:  aluctl = ALU_XOR;
               3'b101:  aluctl = alt ? ALU_SRA : ALU_SRL;
               3'b110:  aluctl = ALU_OR;
               default: aluctl = ALU_AND;
            endcase
         end
         default:  aluctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with imem/dmem/execute handshakes and TRAP.
// Define RV_MULDIV_EN to enable the M-op EXSTART/EXWAIT path and its watchdog.
module mc_ctrl_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int EX_TIMEOUT = 64,
   parameter int CNT_W      = $clog2(EX_TIMEOUT + 1),
   parameter bit TRAP_HALT  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [1:0] func7b50,
   input  logic       imem_rdy,
   input  logic       dmem_rdy,
   input  logic       exdone,
   input  logic       br_taken,
   output logic       instrre,
   output logic       pcnextctl,
   output logic [1:0] pcmuxctl,
   output logic       regwe,
   output logic [3:0] aluctl,
   output logic [1:0] mulctl,
   output logic       exstart,
   output logic [1:0] ifuresctl,
   output logic       dmemre,
   output logic       dmemwe,
   output logic       trap,
   output logic [1:0] cause
);

   if (EX_TIMEOUT < 2) begin : g_bad_timeout
      $error("mc_ctrl_fsm: EX_TIMEOUT must be at least 2");
   end
   if (CNT_W < $clog2(EX_TIMEOUT + 1)) begin : g_bad_cnt_w
      $error("mc_ctrl_fsm: CNT_W too narrow for EX_TIMEOUT");
   end

   state_t     state, state_nx;
   iclass_t    cls;
   logic [2:0] f3;
   logic       alt;
   logic [1:0] cause_q, cause_nx;
   logic [3:0] alu_op;
   decode_t    dec;

   assign dec   = classify(opcode, func7b50);
   assign cause = cause_q;

   rv_alu_dec u_alu_dec (
      .cls    (cls),
      .func3  (f3),
      .alt    (alt),
      .aluctl (alu_op)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         cls     <= C_OP;
         f3      <= '0;
         alt     <= 1'b0;
         cause_q <= CAUSE_ILLEGAL;
      end else begin
         state   <= state_nx;
         cause_q <= cause_nx;
         if (state == S_DECODE) begin
            cls <= dec.cls;
            f3  <= func3;
            alt <= func7b50[1];
         end
      end
   end

`ifdef RV_MULDIV_EN
   logic [CNT_W-1:0] wdog;

   // Counts EXWAIT cycles without exdone; cleared on every new execute start.
   always_ff @(posedge clk) begin
      if (rst || state == S_EXSTART) wdog <= '0;
      else if (state == S_EXWAIT && !exdone) wdog <= wdog + CNT_W'(1);
   end
`else
   logic unused_exdone;
   assign unused_exdone = exdone;
`endif

   always_comb begin
      state_nx  = state;
      cause_nx  = cause_q;
      instrre   = 1'b0;
      pcnextctl = 1'b0;
      pcmuxctl  = PC_PLUS4;
      regwe     = 1'b0;
      aluctl    = ALU_ADD;
      mulctl    = 2'b00;
      exstart   = 1'b0;
      ifuresctl = RES_ALU;
      dmemre    = 1'b0;
      dmemwe    = 1'b0;
      trap      = 1'b0;
      case (state)
         S_FETCH: begin
            if (imem_rdy) begin
               instrre  = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!dec.legal) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_ILLEGAL;
            end else if (dec.cls == C_MOP) begin
`ifdef RV_MULDIV_EN
               state_nx = S_EXSTART;
`else
               state_nx = S_TRAP;
               cause_nx = CAUSE_MDIS;
`endif
            end else begin
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            aluctl = alu_op;
            case (cls)
               C_LOAD, C_STORE: state_nx = S_MEM;
               C_BRANCH: begin
                  pcnextctl = 1'b1;
                  pcmuxctl  = br_taken ? PC_BRANCH : PC_PLUS4;
                  state_nx  = S_FETCH;
               end
               default: state_nx = S_WB;
            endcase
         end
`ifdef RV_MULDIV_EN
         S_EXSTART: begin
            exstart  = 1'b1;
            mulctl   = f3[1:0];
            state_nx = S_EXWAIT;
         end
         S_EXWAIT: begin
            mulctl = f3[1:0];
            // exdone takes priority over a watchdog expiry in the same cycle.
            if (exdone) begin
               state_nx = S_WB;
            end else if (wdog == CNT_W'(EX_TIMEOUT - 1)) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_TIMEOUT;
            end
         end
`endif
         S_MEM: begin
            if (cls == C_STORE) dmemwe = 1'b1;
            else                dmemre = 1'b1;
            if (dmem_rdy) begin
               if (cls == C_STORE) begin
                  pcnextctl = 1'b1;
                  state_nx  = S_FETCH;
               end else begin
                  state_nx  = S_WB;
               end
            end
         end
         S_WB: begin
            regwe     = 1'b1;
            pcnextctl = 1'b1;
            state_nx  = S_FETCH;
            case (cls)
               C_JAL:   begin pcmuxctl = PC_BRANCH; ifuresctl = RES_PC4; end
               C_JALR:  begin pcmuxctl = PC_JALR;   ifuresctl = RES_PC4; end
               C_LOAD:  ifuresctl = RES_MEM;
               C_MOP:   ifuresctl = RES_MUL;
               default: ifuresctl = RES_ALU;
            endcase
         end
         S_TRAP: begin
            trap = 1'b1;
            if (!TRAP_HALT) begin
               pcnextctl = 1'b1;
               pcmuxctl  = PC_TRAP;
               state_nx  = S_FETCH;
            end
         end
         default: state_nx = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one halting-TRAP and one one-cycle-TRAP
// instance driven in lockstep, every output checked each cycle.
module tb_mc_ctrl_fsm;
   import rv_ctrl_pkg::*;

   typedef struct packed {
      logic       instrre;
      logic       pcnextctl;
      logic [1:0] pcmuxctl;
      logic       regwe;
      logic [3:0] aluctl;
      logic [1:0] mulctl;
      logic       exstart;
      logic [1:0] ifuresctl;
      logic       dmemre;
      logic       dmemwe;
      logic       trap;
      logic [1:0] cause;
   } outs_t;

   logic       clk, rst;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [1:0] func7b50;
   logic       imem_rdy, dmem_rdy, exdone, br_taken;

   logic       instrre0, pcnextctl0, regwe0, exstart0, dmemre0, dmemwe0, trap0;
   logic [1:0] pcmuxctl0, mulctl0, ifuresctl0, cause0;
   logic [3:0] aluctl0;
   logic       instrre1, pcnextctl1, regwe1, exstart1, dmemre1, dmemwe1, trap1;
   logic [1:0] pcmuxctl1, mulctl1, ifuresctl1, cause1;
   logic [3:0] aluctl1;

   outs_t act0, act1, e, e1;
   int    checks = 0;
   int    errors = 0;

   mc_ctrl_fsm #(.EX_TIMEOUT(8), .TRAP_HALT(1'b1)) dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b50(func7b50),
      .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .exdone(exdone), .br_taken(br_taken),
      .instrre(instrre0), .pcnextctl(pcnextctl0), .pcmuxctl(pcmuxctl0), .regwe(regwe0),
      .aluctl(aluctl0), .mulctl(mulctl0), .exstart(exstart0), .ifuresctl(ifuresctl0),
      .dmemre(dmemre0), .dmemwe(dmemwe0), .trap(trap0), .cause(cause0)
   );

   mc_ctrl_fsm #(.EX_TIMEOUT(8), .TRAP_HALT(1'b0)) dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b50(func7b50),
      .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .exdone(exdone), .br_taken(br_taken),
      .instrre(instrre1), .pcnextctl(pcnextctl1), .pcmuxctl(pcmuxctl1), .regwe(regwe1),
      .aluctl(aluctl1), .mulctl(mulctl1), .exstart(exstart1), .ifuresctl(ifuresctl1),
      .dmemre(dmemre1), .dmemwe(dmemwe1), .trap(trap1), .cause(cause1)
   );

   assign act0 = '{instrre0, pcnextctl0, pcmuxctl0, regwe0, aluctl0, mulctl0, exstart0,
                   ifuresctl0, dmemre0, dmemwe0, trap0, cause0};
   assign act1 = '{instrre1, pcnextctl1, pcmuxctl1, regwe1, aluctl1, mulctl1, exstart1,
                   ifuresctl1, dmemre1, dmemwe1, trap1, cause1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic at();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk2(input string tag, input outs_t exp0, input outs_t exp1);
      checks++;
      assert (act0 === exp0) else begin
         errors++;
         $error("FAIL %s dut0 observed=%h expected=%h", tag, act0, exp0);
      end
      checks++;
      assert (act1 === exp1) else begin
         errors++;
         $error("FAIL %s dut1 observed=%h expected=%h", tag, act1, exp1);
      end
   endtask

   task automatic chk(input string tag, input outs_t exp);
      chk2(tag, exp, exp);
   endtask

   task automatic do_reset(input string tag);
      imem_rdy = 1'b0; dmem_rdy = 1'b0; exdone = 1'b0; br_taken = 1'b0;
      rst = 1'b1;
      at();
      at();
      settle();
      chk(tag, '0);
      rst = 1'b0;
   endtask

   // Waits `gap` FETCH cycles, delivers the instruction, then checks the DECODE cycle.
   task automatic fetch(input int gap, input logic [6:0] op, input logic [2:0] f3,
                        input logic [1:0] f7, input string tag);
      outs_t x;
      for (int i = 0; i < gap; i++) begin
         at(); imem_rdy = 1'b0; dmem_rdy = 1'b0; exdone = 1'b0; br_taken = 1'b0;
         settle(); chk({tag, "_fetch_wait"}, '0);
      end
      at(); imem_rdy = 1'b1; dmem_rdy = 1'b0; exdone = 1'b0; br_taken = 1'b0;
      opcode = op; func3 = f3; func7b50 = f7;
      settle(); x = '0; x.instrre = 1'b1; chk({tag, "_fetch"}, x);
      at(); imem_rdy = 1'b0;
      settle(); chk({tag, "_decode"}, '0);
   endtask

   logic [6:0] t_op  [8] = '{OP_OP, OP_OP, OP_IMM, OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_OP};
   logic [2:0] t_f3  [8] = '{3'b100, 3'b000, 3'b101, 3'b011, 3'b110, 3'b000, 3'b011, 3'b001};
   logic [1:0] t_f7  [8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
   logic [3:0] t_alu [8] = '{ALU_XOR, ALU_SUB, ALU_SRA, ALU_SLTU, ALU_OR, ALU_PASSB, ALU_ADD, ALU_SLL};

   initial begin
      rst = 1'b1; opcode = '0; func3 = '0; func7b50 = '0;
      imem_rdy = 1'b0; dmem_rdy = 1'b0; exdone = 1'b0; br_taken = 1'b0;
      do_reset("reset");

      // ADDI with imem_rdy delayed three cycles
      fetch(3, OP_IMM, 3'b000, 2'b00, "addi");
      at(); settle(); chk("addi_exec", '0);
      at(); settle(); e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; chk("addi_wb", e);

      // ALU decode table
      for (int i = 0; i < 8; i++) begin
         fetch(0, t_op[i], t_f3[i], t_f7[i], "alu");
         at(); settle(); e = '0; e.aluctl = t_alu[i]; chk("alu_exec", e);
         at(); settle(); e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; chk("alu_wb", e);
      end

      // LW, dmem_rdy on the second MEM cycle
      fetch(0, OP_LOAD, 3'b010, 2'b00, "lw");
      at(); settle(); chk("lw_exec", '0);
      at(); dmem_rdy = 1'b0; settle(); e = '0; e.dmemre = 1'b1; chk("lw_mem1", e);
      at(); dmem_rdy = 1'b1; settle(); chk("lw_mem2", e);
      at(); dmem_rdy = 1'b0; settle();
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.ifuresctl = 2'd2; chk("lw_wb", e);

      // SW, dmem_rdy immediately
      fetch(0, OP_STORE, 3'b010, 2'b00, "sw");
      at(); settle(); chk("sw_exec", '0);
      at(); dmem_rdy = 1'b1; settle();
      e = '0; e.dmemwe = 1'b1; e.pcnextctl = 1'b1; chk("sw_mem", e);

      // BEQ taken / not taken
      fetch(0, OP_BRANCH, 3'b000, 2'b00, "beq_t");
      at(); br_taken = 1'b1; settle();
      e = '0; e.aluctl = ALU_SUB; e.pcnextctl = 1'b1; e.pcmuxctl = 2'd1; chk("beq_t_exec", e);
      fetch(0, OP_BRANCH, 3'b000, 2'b00, "beq_nt");
      at(); br_taken = 1'b0; settle();
      e = '0; e.aluctl = ALU_SUB; e.pcnextctl = 1'b1; chk("beq_nt_exec", e);

      // JAL / JALR
      fetch(0, OP_JAL, 3'b000, 2'b00, "jal");
      at(); settle(); chk("jal_exec", '0);
      at(); settle();
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.pcmuxctl = 2'd1; e.ifuresctl = 2'd3;
      chk("jal_wb", e);
      fetch(0, OP_JALR, 3'b000, 2'b00, "jalr");
      at(); settle(); chk("jalr_exec", '0);
      at(); settle();
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.pcmuxctl = 2'd2; e.ifuresctl = 2'd3;
      chk("jalr_wb", e);

`ifdef RV_MULDIV_EN
      // MUL, exdone on the fifth EXWAIT cycle
      fetch(0, OP_OP, 3'b000, 2'b01, "mul");
      at(); settle(); e = '0; e.exstart = 1'b1; chk("mul_exstart", e);
      for (int i = 0; i < 4; i++) begin
         at(); exdone = 1'b0; settle(); chk("mul_wait", '0);
      end
      at(); exdone = 1'b1; settle(); chk("mul_done", '0);
      at(); exdone = 1'b0; settle();
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.ifuresctl = 2'd1; chk("mul_wb", e);

      // MULHU, no exdone: timeout after 8 EXWAIT cycles
      fetch(0, OP_OP, 3'b011, 2'b01, "to");
      at(); settle(); e = '0; e.exstart = 1'b1; e.mulctl = 2'd3; chk("to_exstart", e);
      for (int i = 0; i < 8; i++) begin
         at(); settle(); e = '0; e.mulctl = 2'd3; chk("to_wait", e);
      end
      at(); settle();
      e = '0; e.trap = 1'b1; e.cause = 2'd2;
      e1 = e; e1.pcnextctl = 1'b1; e1.pcmuxctl = 2'd3;
      chk2("to_trap", e, e1);
      at(); settle(); e1 = '0; e1.cause = 2'd2; chk2("to_trap_next", e, e1);
      do_reset("to_reset");

      // exdone on the final allowed cycle wins over the timeout
      fetch(0, OP_OP, 3'b000, 2'b01, "edge");
      at(); settle(); e = '0; e.exstart = 1'b1; chk("edge_exstart", e);
      for (int i = 0; i < 7; i++) begin
         at(); settle(); chk("edge_wait", '0);
      end
      at(); exdone = 1'b1; settle(); chk("edge_done", '0);
      at(); exdone = 1'b0; settle();
      e = '0; e.regwe = 1'b1; e.pcnextctl = 1'b1; e.ifuresctl = 2'd1; chk("edge_wb", e);

      // Reset while waiting on execute
      fetch(0, OP_OP, 3'b000, 2'b01, "rstw");
      at(); settle(); e = '0; e.exstart = 1'b1; chk("rstw_exstart", e);
      at(); settle(); chk("rstw_wait", '0);
      rst = 1'b1;
      at(); rst = 1'b0; settle(); chk("rstw_fetch", '0);
      at(); settle(); chk("rstw_idle", '0);
`else
      // M-op without the multiply unit traps with cause 1
      fetch(0, OP_OP, 3'b000, 2'b01, "mdis");
      at(); settle();
      e = '0; e.trap = 1'b1; e.cause = 2'd1;
      e1 = e; e1.pcnextctl = 1'b1; e1.pcmuxctl = 2'd3;
      chk2("mdis_trap", e, e1);
      at(); settle(); e1 = '0; e1.cause = 2'd1; chk2("mdis_trap_next", e, e1);
      do_reset("mdis_reset");
`endif

      // Illegal opcode: sticky trap on dut0, one-cycle trap then FETCH on dut1
      fetch(0, 7'b1111111, 3'b000, 2'b00, "ill");
      at(); settle();
      e = '0; e.trap = 1'b1; e.cause = 2'd0;
      e1 = e; e1.pcnextctl = 1'b1; e1.pcmuxctl = 2'd3;
      chk2("ill_trap", e, e1);
      at(); imem_rdy = 1'b1; settle();
      e1 = '0; e1.instrre = 1'b1; chk2("ill_trap_next", e, e1);
      at(); imem_rdy = 1'b0; settle(); chk2("ill_trap_sticky", e, '0);
      do_reset("ill_reset");

      // Reset while a load is outstanding
      fetch(0, OP_LOAD, 3'b000, 2'b00, "rstm");
      at(); settle(); chk("rstm_exec", '0);
      at(); dmem_rdy = 1'b0; settle(); e = '0; e.dmemre = 1'b1; chk("rstm_mem", e);
      rst = 1'b1;
      at(); rst = 1'b0; settle(); chk("rstm_fetch", '0);
      at(); settle(); chk("rstm_idle", '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
